vis_bank_ctrl: RTL

Bus-domain bank manager and visibility readout sequencer, directly downstream of the correlator bank-switch stage. It consumes the one-cycle bus-domain swap pulse, maintains the circular set of completed visibility banks and supplies the bank index the correlator writes into. On request it streams the oldest completed bank out of visibility memory over a valid/ready interface, then releases that bank for reuse.

---
 rtl/vis_bank_pkg.sv | 26 ++
 rtl/vis_bank_ctrl_if.sv | 29 ++
 rtl/vis_skid.sv | 72 +++++++
 rtl/vis_bank_ctrl.sv | 136 +++++++++++++
 4 files changed

// File: rtl/vis_bank_pkg.sv
// Shared definitions for the visibility bank manager: default geometry,
// readout FSM encoding and a constant-width helper.
package vis_bank_pkg;

  localparam int BANKS_DEF = 16;
  localparam int WORDS_DEF = 576;
  localparam int ABITS_DEF = 10;
  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Smallest r with 2**r >= value; sizes the bank index.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < value) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/vis_bank_ctrl_if.sv
// Visibility-memory read port plus the valid/ready readout stream.
// The master side is the bank controller; the slave side is memory plus sink.
interface vis_bank_ctrl_if
  import vis_bank_pkg::*;
#(
  parameter int BBITS = clog2(BANKS_DEF),
  parameter int ABITS = ABITS_DEF,
  parameter int WIDTH = WIDTH_DEF
);

  logic                   rd_en_o;
  logic [BBITS+ABITS-1:0] rd_adr_o;
  logic [WIDTH-1:0]       rd_dat_i;
  logic [WIDTH-1:0]       dat_o;
  logic                   valid_o;
  logic                   ready_i;
  logic                   last_o;

  modport master (
    output rd_en_o, rd_adr_o, dat_o, valid_o, last_o,
    input  rd_dat_i, ready_i
  );

  modport slave (
    input  rd_en_o, rd_adr_o, dat_o, valid_o, last_o,
    output rd_dat_i, ready_i
  );

endinterface

// File: rtl/vis_skid.sv
// Two-entry FIFO carrying {last, data} between the memory read port and the
// readout stream; the head entry drives registered valid/dat/last outputs.
module vis_skid
  import vis_bank_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] in_dat,
  input  logic             in_last,
  output logic [1:0]       entries,
  output logic             valid,
  output logic [WIDTH-1:0] dat,
  output logic             last
);

  logic [WIDTH-1:0] tail_dat;
  logic             tail_last;
  logic             tail_wr;

  // The tail is written when a push lands behind an entry that stays put.
  assign tail_wr = push && (((entries == 2'd1) && !pop) || ((entries == 2'd2) && pop));

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entries <= 2'd0;
      valid   <= 1'b0;
      dat     <= '0;
      last    <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (entries == 2'd0) begin
            dat   <= in_dat;
            last  <= in_last;
            valid <= 1'b1;
          end
          entries <= entries + 2'd1;
        end
        2'b01: begin
          dat     <= tail_dat;
          last    <= tail_last;
          valid   <= (entries == 2'd2);
          entries <= entries - 2'd1;
        end
        2'b11: begin
          if (entries == 2'd1) begin
            dat  <= in_dat;
            last <= in_last;
          end else begin
            dat  <= tail_dat;
            last <= tail_last;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: tail storage has no reset; it is only read once entries says it holds data.
  always_ff @(posedge clk_i) begin
    if (tail_wr) begin
      tail_dat  <= in_dat;
      tail_last <= in_last;
    end
  end

endmodule

// File: rtl/vis_bank_ctrl.sv
// Bus-domain bank manager: tracks completed visibility banks, hands the
// correlator its write bank, and streams the oldest bank out on request.
module vis_bank_ctrl
  import vis_bank_pkg::*;
#(
  parameter int BANKS = BANKS_DEF,
  parameter int BBITS = clog2(BANKS),
  parameter int WORDS = WORDS_DEF,
  parameter int ABITS = ABITS_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             swap_i,
  input  logic             clear_i,
  input  logic             fetch_i,
  output logic [BBITS-1:0] wbank_o,
  output logic             avail_o,
  output logic             overflow_o,
  output logic             busy_o,
  output logic             done_o,
  vis_bank_ctrl_if.master  bus
);

  localparam logic [BBITS-1:0] LEVEL_FULL = BBITS'(BANKS - 1);
  localparam logic [ABITS-1:0] LAST_WORD  = ABITS'(WORDS - 1);

  state_e           state_q, state_d;
  logic [BBITS-1:0] wbank_q, rbank_q, level_q, cur_q;
  logic [ABITS-1:0] word_q;
  logic             inflight_q, rd_last_q, overflow_q, done_q;

  logic             full, swap_ok, rd_en, start, rel, pop;
  logic [1:0]       entries;
  logic [2:0]       occ;

  assign full    = (level_q == LEVEL_FULL);
  assign swap_ok = swap_i && !full;
  assign pop     = bus.valid_o && bus.ready_i;

  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latch).
    state_d = state_q;
    rd_en   = 1'b0;
    start   = 1'b0;
    rel     = 1'b0;
    // Projected buffer fill once the in-flight read lands and this cycle's pop leaves.
    occ     = {1'b0, entries} + {2'b00, inflight_q} - {2'b00, pop};
    case (state_q)
      ST_IDLE: begin
        if (fetch_i && avail_o) begin
          start   = 1'b1;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (occ <= 3'd1) begin
          rd_en = 1'b1;
          if (word_q == LAST_WORD) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && bus.last_o) begin
          rel     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cur_q      <= '0;
      word_q     <= '0;
      inflight_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= rd_en;
      rd_last_q  <= rd_en && (word_q == LAST_WORD);
      if (start) begin
        cur_q  <= rbank_q;
        word_q <= '0;
      end else if (rd_en && (word_q != LAST_WORD)) begin
        word_q <= word_q + ABITS'(1);
      end
    end
  end

  // Fullness is judged on the pre-release level, so a full swap overflows
  // even when a bank is released in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wbank_q    <= '0;
      rbank_q    <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      if (swap_ok) wbank_q <= wbank_q + BBITS'(1);
      if (rel)     rbank_q <= rbank_q + BBITS'(1);
      case ({swap_ok, rel})
        2'b10:   level_q <= level_q + BBITS'(1);
        2'b01:   level_q <= level_q - BBITS'(1);
        default: ;
      endcase
      if (swap_i && full) overflow_q <= 1'b1;
      else if (clear_i)   overflow_q <= 1'b0;
      done_q <= rel;
    end
  end

  vis_skid #(.WIDTH(WIDTH)) u_skid (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push    (inflight_q),
    .pop     (pop),
    .in_dat  (bus.rd_dat_i),
    .in_last (rd_last_q),
    .entries (entries),
    .valid   (bus.valid_o),
    .dat     (bus.dat_o),
    .last    (bus.last_o)
  );

  assign bus.rd_en_o  = rd_en;
  assign bus.rd_adr_o = {cur_q, word_q};
  assign wbank_o      = wbank_q;
  assign avail_o      = (level_q != '0);
  assign overflow_o   = overflow_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = done_q;

endmodule
